// File: rtl/stack_pkg.sv
// Shared constants for the stack controller: word width, op codes,
// stack-step encodings, FSM states and the command legality rule.
package stack_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] OP_PUSH    = 3'd0;
  localparam logic [2:0] OP_POP     = 3'd1;
  localparam logic [2:0] OP_REPLACE = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_DROPN   = 3'd6;

  // stack2 delta field; a replace is we=1 with D_NONE
  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_PUSH = 2'b01;
  localparam logic [1:0] D_POP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP1,
    S_STEP2,
    S_STEP3,
    S_DROP
  } state_t;

  function automatic logic cmd_legal(logic [2:0] op, int d, int n, int cap);
    case (op)
      OP_PUSH:             return d < cap;
      OP_POP, OP_REPLACE:  return d >= 1;
      OP_DUP:              return (d >= 1) && (d < cap);
      OP_SWAP:             return d >= 2;
      OP_OVER:             return (d >= 2) && (d < cap);
      OP_DROPN:            return n <= d;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack2.sv
// Head register plus a DEPTH-word shift-register tail.
// we writes the head; delta moves the tail (push shifts the old head in).
module stack2
  import stack_pkg::*;
#(
  parameter int DEPTH = 18
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        delta,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd
);

  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] tail [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      head <= wd;
    else if (delta == D_POP)
      head <= tail[0];

    if (delta == D_PUSH) begin
      tail[0] <= head;
      for (int i = 1; i < DEPTH; i++) tail[i] <= tail[i-1];
    end else if (delta == D_POP) begin
      for (int i = 0; i < DEPTH - 1; i++) tail[i] <= tail[i+1];
      tail[DEPTH-1] <= '0;
    end
  end

  assign rd = head;

endmodule

// File: rtl/stack_ctl.sv
// Command sequencer around stack2: legality check, multi-step SWAP/OVER/DROPN
// sequencing and word-count tracking.
module stack_ctl
  import stack_pkg::*;
#(
  parameter  int DEPTH = 18,
  localparam int CAP   = DEPTH + 1,
  localparam int DW    = $clog2(CAP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WORD_W-1:0] cmd_data,
  input  logic [4:0]        cmd_n,
  output logic [WORD_W-1:0] tos,
  output logic [DW-1:0]     depth,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [2:0]        op_q;
  logic [4:0]        cnt;
  logic [WORD_W-1:0] t_q;
  logic              st_we;
  logic [1:0]        st_delta;
  logic [WORD_W-1:0] st_wd;
  logic [WORD_W-1:0] rd;
  logic              legal;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign legal     = cmd_legal(cmd_op, int'(depth), int'(cmd_n), CAP);
  assign tos       = rd;

  // Step registers feed stack2 one cycle after being set; depth follows the
  // step as it is consumed, so both move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      depth    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      st_we    <= 1'b0;
      st_delta <= D_NONE;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      st_we    <= 1'b0;
      st_delta <= D_NONE;

      if (st_delta == D_PUSH)
        depth <= depth + 1'b1;
      else if (st_delta == D_POP)
        depth <= depth - 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            t_q  <= rd;
            if (!legal) begin
              err <= 1'b1;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  st_we <= 1'b1; st_delta <= D_PUSH; st_wd <= cmd_data; state <= S_STEP1;
                end
                OP_REPLACE: begin
                  st_we <= 1'b1; st_wd <= cmd_data; state <= S_STEP1;
                end
                OP_DUP: begin
                  st_we <= 1'b1; st_delta <= D_PUSH; st_wd <= rd; state <= S_STEP1;
                end
                OP_POP, OP_SWAP, OP_OVER: begin
                  st_delta <= D_POP; state <= S_STEP1;
                end
                default: begin
                  if (cmd_n == 5'd0) begin
                    done <= 1'b1;
                  end else begin
                    st_delta <= D_POP; cnt <= cmd_n; state <= S_DROP;
                  end
                end
              endcase
            end
          end
        end
        S_STEP1: begin
          if (op_q == OP_SWAP) begin
            st_we <= 1'b1; st_wd <= t_q; state <= S_STEP2;
          end else if (op_q == OP_OVER) begin
            st_we <= 1'b1; st_delta <= D_PUSH; st_wd <= t_q; state <= S_STEP2;
          end else begin
            done <= 1'b1; state <= S_IDLE;
          end
        end
        // rd still shows N here: step 2 is only consumed at this edge
        S_STEP2: begin
          st_we <= 1'b1; st_delta <= D_PUSH; st_wd <= rd; state <= S_STEP3;
        end
        S_STEP3: begin
          done <= 1'b1; state <= S_IDLE;
        end
        S_DROP: begin
          if (cnt == 5'd1) begin
            done <= 1'b1; state <= S_IDLE;
          end else begin
            st_delta <= D_POP; cnt <= cnt - 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  stack2 #(.DEPTH(DEPTH)) u_stack2 (
    .clk   (clk),
    .we    (st_we && !reset),
    .delta (reset ? D_NONE : st_delta),
    .wd    (st_wd),
    .rd    (rd)
  );

endmodule

// File: tb/tb_stack_ctl.sv
// Directed bench for stack_ctl: command latency, results, legality and
// reset-abort behaviour with hand-computed expectations.
module tb_stack_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [4:0]  cmd_n;
  logic [15:0] tos;
  logic [4:0]  depth;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_ctl #(.DEPTH(18)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_n     (cmd_n),
    .tos       (tos),
    .depth     (depth),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the controller idle. exp_cyc counts cycles from
  // acceptance to done (L+1); exp_err expects a rejection in the next cycle.
  task automatic send(input string tag, input logic [2:0] op, input logic [15:0] d,
                      input logic [4:0] n, input int exp_cyc, input bit exp_err);
    int cyc;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_n = n;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_data = 16'hxxxx; cmd_n = 5'd31;
    cyc = 1;
    if (exp_err) begin
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
    end else begin
      while (!done && cyc < 60) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_noerr"}, 32'(err), 32'd0);
      chk({tag, "_rdy_at_done"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0; cmd_n = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    send("push1", 3'd0, 16'h1111, 5'd0, 2, 1'b0);
    chk("push1_tos", 32'(tos), 32'h1111);
    send("push2", 3'd0, 16'h2222, 5'd0, 2, 1'b0);
    send("push3", 3'd0, 16'h3333, 5'd0, 2, 1'b0);
    chk("push3_tos", 32'(tos), 32'h3333);
    chk("push3_depth", 32'(depth), 32'd3);

    send("swap", 3'd4, 16'h0, 5'd0, 4, 1'b0);
    chk("swap_tos", 32'(tos), 32'h2222);
    chk("swap_depth", 32'(depth), 32'd3);
    send("swap_pop", 3'd1, 16'h0, 5'd0, 2, 1'b0);
    chk("swap_pop_tos", 32'(tos), 32'h3333);
    send("pop_a", 3'd1, 16'h0, 5'd0, 2, 1'b0);
    chk("pop_a_tos", 32'(tos), 32'h1111);
    chk("pop_a_depth", 32'(depth), 32'd1);

    send("push_b", 3'd0, 16'h2222, 5'd0, 2, 1'b0);
    send("over", 3'd5, 16'h0, 5'd0, 4, 1'b0);
    chk("over_tos", 32'(tos), 32'h1111);
    chk("over_depth", 32'(depth), 32'd3);
    send("over_pop1", 3'd1, 16'h0, 5'd0, 2, 1'b0);
    chk("over_pop1_tos", 32'(tos), 32'h2222);
    send("over_pop2", 3'd1, 16'h0, 5'd0, 2, 1'b0);
    chk("over_pop2_tos", 32'(tos), 32'h1111);
    send("over_pop3", 3'd1, 16'h0, 5'd0, 2, 1'b0);
    chk("over_pop3_depth", 32'(depth), 32'd0);

    send("pop_empty", 3'd1, 16'h0, 5'd0, 0, 1'b1);
    chk("pop_empty_depth", 32'(depth), 32'd0);
    send("swap_empty", 3'd4, 16'h0, 5'd0, 0, 1'b1);
    send("push_c", 3'd0, 16'h00A5, 5'd0, 2, 1'b0);
    send("replace", 3'd2, 16'h5A5A, 5'd0, 2, 1'b0);
    chk("replace_tos", 32'(tos), 32'h5A5A);
    chk("replace_depth", 32'(depth), 32'd1);
    send("swap_one", 3'd4, 16'h0, 5'd0, 0, 1'b1);
    send("reserved", 3'd7, 16'h0, 5'd0, 0, 1'b1);
    send("dup", 3'd3, 16'h0, 5'd0, 2, 1'b0);
    chk("dup_tos", 32'(tos), 32'h5A5A);
    chk("dup_depth", 32'(depth), 32'd2);
    send("dropn0", 3'd6, 16'h0, 5'd0, 1, 1'b0);
    chk("dropn0_depth", 32'(depth), 32'd2);
    send("dropn2", 3'd6, 16'h0, 5'd2, 3, 1'b0);
    chk("dropn2_depth", 32'(depth), 32'd0);

    for (int i = 0; i < 19; i++)
      send("fill", 3'd0, 16'h1000 + 16'(i), 5'd0, 2, 1'b0);
    chk("fill_depth", 32'(depth), 32'd19);
    chk("fill_tos", 32'(tos), 32'h1012);
    send("push_full", 3'd0, 16'hBEEF, 5'd0, 0, 1'b1);
    chk("push_full_depth", 32'(depth), 32'd19);
    chk("push_full_tos", 32'(tos), 32'h1012);
    send("dup_full", 3'd3, 16'h0, 5'd0, 0, 1'b1);
    send("dropn20", 3'd6, 16'h0, 5'd20, 0, 1'b1);
    chk("dropn20_depth", 32'(depth), 32'd19);
    send("dropn19", 3'd6, 16'h0, 5'd19, 20, 1'b0);
    chk("dropn19_depth", 32'(depth), 32'd0);
    send("pop_after_drop", 3'd1, 16'h0, 5'd0, 0, 1'b1);

    send("push_d", 3'd0, 16'h1111, 5'd0, 2, 1'b0);
    send("push_e", 3'd0, 16'h2222, 5'd0, 2, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_done", 32'(done), 32'd0);
    chk("abort_rst_depth", 32'(depth), 32'd0);
    chk("abort_rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_depth", 32'(depth), 32'd0);
    send("push_42", 3'd0, 16'h0042, 5'd0, 2, 1'b0);
    chk("push_42_tos", 32'(tos), 32'h0042);
    chk("push_42_depth", 32'(depth), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctl.md
STACK_CTL -- requirements
Module: stack_ctl

Interface
REQ-001 Parameter DEPTH, default 18: tail depth of the wrapped stack2 instance; capacity CAP = DEPTH+1 words, counting the head.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller can accept a command; high only in IDLE.
REQ-006 cmd_op  input  3  0=PUSH, 1=POP, 2=REPLACE, 3=DUP, 4=SWAP, 5=OVER, 6=DROPN, 7=reserved.
REQ-007 cmd_data  input  16  operand for PUSH and REPLACE.
REQ-008 cmd_n  input  5  pop count for DROPN.
REQ-009 tos  output  16  current top of stack, taken directly from stack2 rd.
REQ-010 depth  output  clog2(CAP+1)  number of valid words, 0..CAP.
REQ-011 done  output  1  one-cycle pulse when an accepted command completes; tos and depth already reflect the result.
REQ-012 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-013 A command is accepted in cycle t when cmd_valid and cmd_ready are both high; op, data and n are registered at t.
REQ-014 Legality is checked at t against depth; an illegal command returns err=1 at t+1, causes no stack writes, leaves depth unchanged, and keeps the controller in IDLE.
REQ-015 Legality rules:
- PUSH: depth<CAP.
- POP, REPLACE: depth>=1.
- DUP: 1<=depth<CAP.
- SWAP: depth>=2.
- OVER: 2<=depth<CAP.
- DROPN: n<=depth.
- Reserved op: always illegal.
REQ-016 A legal command drives stack steps in cycles t+1..t+L, then pulses done at t+L+1 with the FSM back in IDLE (cmd_ready=1 in that same cycle).
REQ-017 Stack step encodings on stack2 (we, delta): push=(1,01); pop=(0,11); replace=(1,00); idle=(0,00).
REQ-018 Single-step ops, L=1:
- PUSH: push cmd_data.
- POP: pop.
- REPLACE: replace with cmd_data.
- DUP: push tos.
REQ-019 SWAP, L=3:
- step 1: save T=tos, pop.
- step 2: save N=tos, replace with T.
- step 3: push N.
REQ-020 OVER, L=3:
- step 1: save T=tos, pop.
- step 2: save N=tos, push T.
- step 3: push N.
REQ-021 DROPN: L=n pops on consecutive cycles; n=0 gives done at t+1 with no stack writes.
REQ-022 FSM states: IDLE, STEP1, STEP2, STEP3, DROP. DROP uses a down-counter loaded with n and exits when the counter reaches 1.
REQ-023 depth updates on the same edge as each push or pop step: +1 on push, -1 on pop, unchanged on replace. Net result: SWAP 0, OVER +1, DROPN -n.
REQ-024 cmd_valid is ignored outside IDLE; cmd_op, cmd_data and cmd_n may change freely after acceptance.
REQ-025 done and err never assert in the same cycle; both are 0 in any cycle where no command completes or is rejected.
REQ-026 Words below depth are don't-care; stack2 fill values are never exposed as valid data.

Reset
REQ-027 While reset is high: state=IDLE, depth=0, done=0, err=0, cmd_ready=0, and the stack2 interface is driven idle (we=0, delta=00).
REQ-028 cmd_ready=1 in the first cycle after reset deasserts.
REQ-029 A reset during a multi-cycle op aborts it: no done, no err, and no further stack writes. tos is undefined until the first push.

Structure
REQ-030 Shared package stack_pkg holds the op-code constants, the stack word width (16), and the stack-step (we, delta) encodings.
REQ-031 One sub-module: a single stack2 instance with DEPTH passed through. All sequencing, depth counting and legality checking are in stack_ctl.

Verification
REQ-032 Reset, then PUSH 0x1111, 0x2222, 0x3333 -> each done one cycle after its step; final tos=0x3333, depth=3.
REQ-033 From {top 0x3333, 0x2222, 0x1111}, SWAP -> done at t+4; tos=0x2222, depth=3; then POP -> tos=0x3333.
REQ-034 From {0x2222, 0x1111}, OVER -> done at t+4; stack reads 0x1111, 0x2222, 0x1111 top-down; depth=3.
REQ-035 Push 19 words, then PUSH 0xBEEF -> err at t+1, depth stays 19, tos unchanged; DROPN n=19 -> done at t+20, depth=0; POP -> err.
REQ-036 Assert reset during step 2 of SWAP -> no done, depth=0, cmd_ready=1 one cycle after reset deasserts; PUSH 0x0042 -> tos=0x0042, depth=1.
